alu_unit: RTL and testbench
===========================

// Module: alu_unit
// PURPOSE
// - 16-function integer ALU: two WIDTH-bit operands A and B, 4-bit opcode ALU_Sel.
// - Produces a WIDTH-bit result ALU_Out and an adder carry flag CarryOut.
// - One clock, output-registered: the combinational datapath feeds the output flops.
// - Arithmetic/logic leaf of the datapath, driven by the testbench interface intf;
//   the clock comes from clk_if.
// PARAMETERS
// - WIDTH  8  operand and result width in bits; must be >= 2.
// PORTS
// - clk       in   1      rising-edge clock, supplied through clk_if.
// - rst_n     in   1      reset; synchronous, active-low.
// - A         in   WIDTH  operand A.
// - B         in   WIDTH  operand B.
// - ALU_Sel   in   4      opcode, encoded as alu_pkg::alu_op_e.
// - ALU_Out   out  WIDTH  registered result.
// - CarryOut  out  1      registered carry: bit WIDTH of the zero-extended sum A+B.
// BEHAVIOUR
// - Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
// - Reset: rst_n=0 at a rising edge sets ALU_Out=0 and CarryOut=0. This overrides any
//   operation in flight; the first valid result appears 1 cycle after rst_n returns high.
// - Latency: 1 cycle, full throughput. Inputs sampled at edge N appear on the outputs
//   after edge N and hold until edge N+1. There is no handshake.
// - Opcodes (all results truncated to WIDTH bits, operands unsigned):
//   - 0000 ADD  A+B
//   - 0001 SUB  A-B, two's-complement wrap
//   - 0010 MUL  low WIDTH bits of A*B
//   - 0011 DIV  A/B; B==0 gives all-ones
//   - 0100 SHL  A<<1, LSB filled with 0
//   - 0101 SHR  A>>1, MSB filled with 0
//   - 0110 ROL  {A[W-2:0],A[W-1]}
//   - 0111 ROR  {A[0],A[W-1:1]}
//   - 1000 AND  A&B
//   - 1001 OR   A|B
//   - 1010 XOR  A^B
//   - 1011 NOR  ~(A|B)
//   - 1100 NAND ~(A&B)
//   - 1101 XNOR ~(A^B)
//   - 1110 GT   (A>B) ? 1 : 0, zero-extended
//   - 1111 EQ   (A==B) ? 1 : 0, zero-extended
// - CarryOut: ({1'b0,A}+{1'b0,B})[WIDTH] for every opcode, not only ADD.
// - Shifts and rotates ignore B.
// - X/Z on ALU_Sel: drive ALU_Out=0, CarryOut unchanged. The case default yields 0;
//   no latches.
// STRUCTURE
// - alu_pkg holds: typedef enum logic [3:0] alu_op_e (ALU_ADD..ALU_EQ, codes as above)
//   and localparam ALU_SEL_W=4.
// - Sub-module alu_comb (WIDTH): purely combinational; outputs res_d and carry_d.
// - alu_unit instantiates alu_comb and adds the reset-gated output flops only.
// TESTING
// - Reset: hold rst_n=0 for 2 cycles with A=8'hFF, B=8'h01, ALU_Sel=0000
//   -> ALU_Out=0, CarryOut=0. After release, 1 edge -> ALU_Out=8'h00, CarryOut=1.
// - SHL: ALU_Sel=0100, A=8'h81, B=8'h7F -> ALU_Out=8'h02 one cycle later, CarryOut=1.
//   Also A=8'h40 -> 8'h80.
// - Arithmetic corners:
//   - SUB 8'h00-8'h01 -> 8'hFF.
//   - MUL 8'h10*8'h10 -> 8'h00.
//   - DIV 8'h64/8'h07 -> 8'h0E.
//   - DIV 8'h05/8'h00 -> 8'hFF.
// - Rotates: ROL 8'h81 -> 8'h03; ROR 8'h81 -> 8'hC0; SHR 8'h81 -> 8'h40.
// - Logic and compare with A=8'hF0, B=8'h3C:
//   - AND -> 8'h30; OR -> 8'hFC; XOR -> 8'hCC; NOR -> 8'h03; NAND -> 8'hCF;
//     XNOR -> 8'h33.
//   - GT -> 8'h01; EQ -> 8'h00; EQ with A=B=8'h5A -> 8'h01.
// - Pipelining: change the opcode every cycle through all 16 values, then assert
//   rst_n=0 mid-stream.
//   - Each result matches the reference model exactly 1 cycle later.
//   - The cycle after the reset edge shows 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and widths for the ALU slice.
package alu_pkg;

   localparam int unsigned ALU_SEL_W = 4;

   typedef enum logic [ALU_SEL_W-1:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_MUL  = 4'b0010,
      ALU_DIV  = 4'b0011,
      ALU_SHL  = 4'b0100,
      ALU_SHR  = 4'b0101,
      ALU_ROL  = 4'b0110,
      ALU_ROR  = 4'b0111,
      ALU_AND  = 4'b1000,
      ALU_OR   = 4'b1001,
      ALU_XOR  = 4'b1010,
      ALU_NOR  = 4'b1011,
      ALU_NAND = 4'b1100,
      ALU_XNOR = 4'b1101,
      ALU_GT   = 4'b1110,
      ALU_EQ   = 4'b1111
   } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the datapath driver and the ALU.
interface alu_if
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) ();

   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic [ALU_SEL_W-1:0] ALU_Sel;
   logic [WIDTH-1:0]     ALU_Out;
   logic                 CarryOut;

   modport master (
      output A, B, ALU_Sel,
      input  ALU_Out, CarryOut
   );

   modport slave (
      input  A, B, ALU_Sel,
      output ALU_Out, CarryOut
   );

endinterface : alu_if

// File: rtl/alu_comb.sv
// Combinational ALU datapath: result and adder carry, unregistered.
module alu_comb
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   input  logic [ALU_SEL_W-1:0] sel_i,
   output logic [WIDTH-1:0]     res_d,
   output logic                 carry_d
);

   logic [WIDTH:0] sum;

   // Carry is reported for every opcode, so the adder is always live.
   assign sum     = {1'b0, a_i} + {1'b0, b_i};
   assign carry_d = sum[WIDTH];

   always_comb begin
      res_d = '0;
      case (alu_op_e'(sel_i))
         ALU_ADD:  res_d = sum[WIDTH-1:0];
         ALU_SUB:  res_d = a_i - b_i;
         ALU_MUL:  res_d = a_i * b_i;
         ALU_DIV:  res_d = (b_i == '0) ? '1 : a_i / b_i;
         ALU_SHL:  res_d = {a_i[WIDTH-2:0], 1'b0};
         ALU_SHR:  res_d = {1'b0, a_i[WIDTH-1:1]};
         ALU_ROL:  res_d = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
         ALU_ROR:  res_d = {a_i[0], a_i[WIDTH-1:1]};
         ALU_AND:  res_d = a_i & b_i;
         ALU_OR:   res_d = a_i | b_i;
         ALU_XOR:  res_d = a_i ^ b_i;
         ALU_NOR:  res_d = ~(a_i | b_i);
         ALU_NAND: res_d = ~(a_i & b_i);
         ALU_XNOR: res_d = ~(a_i ^ b_i);
         ALU_GT:   res_d = {{(WIDTH-1){1'b0}}, (a_i > b_i)};
         ALU_EQ:   res_d = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
         default:  res_d = '0;
      endcase
   end

endmodule : alu_comb

// File: rtl/alu_unit.sv
// Output-registered 16-function ALU with synchronous active-low reset.
module alu_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   alu_if.slave bus
);

   logic [WIDTH-1:0] res_d;
   logic             carry_d;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;

   alu_comb #(
      .WIDTH (WIDTH)
   ) u_comb (
      .a_i     (bus.A),
      .b_i     (bus.B),
      .sel_i   (bus.ALU_Sel),
      .res_d   (res_d),
      .carry_d (carry_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         carry_q <= carry_d;
      end
   end

   assign bus.ALU_Out  = res_q;
   assign bus.CarryOut = carry_q;

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: expected {result,carry} queued at drive time.
module tb_alu_unit;

   localparam int unsigned W = 8;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
   } vec_t;

   logic clk;
   logic rst_n;
   logic [W:0] exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   alu_if #(.WIDTH(W)) bus ();

   alu_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic carry_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned s;
      s = int'(a) + int'(b);
      return (s > 255);
   endfunction

   // Independent reference: integer arithmetic, truncated at the end.
   function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
      int r;
      case (op)
         4'd0:  r = int'(a) + int'(b);
         4'd1:  r = int'(a) - int'(b) + 256;
         4'd2:  r = int'(a) * int'(b);
         4'd3:  r = (b == 0) ? 255 : int'(a) / int'(b);
         4'd4:  r = int'(a) * 2;
         4'd5:  r = int'(a) / 2;
         4'd6:  r = int'(a) * 2 + int'(a) / 128;
         4'd7:  r = int'(a) / 2 + (int'(a) % 2) * 128;
         4'd8:  r = int'(a & b);
         4'd9:  r = int'(a | b);
         4'd10: r = int'(a ^ b);
         4'd11: r = 255 - int'(a | b);
         4'd12: r = 255 - int'(a & b);
         4'd13: r = 255 - int'(a ^ b);
         4'd14: r = (a > b) ? 1 : 0;
         default: r = (a == b) ? 1 : 0;
      endcase
      return {r[W-1:0], carry_ref(a, b)};
   endfunction

   task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic rst_assert, input logic [W:0] exp);
      rst_n       = ~rst_assert;
      bus.ALU_Sel = op;
      bus.A       = a;
      bus.B       = b;
      exp_q.push_back(exp);
   endtask

   task automatic test_reset();
      logic [W:0] e;
      for (int i = 0; i < 3; i++) begin
         if (i < 2) drive(4'd0, 8'hFF, 8'h01, 1'b1, '0);
         else       drive(4'd0, 8'hFF, 8'h01, 1'b0, {8'h00, 1'b1});
         @(posedge clk); #1;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL reset[%0d]: scoreboard empty", i);
         end else begin
            e = exp_q.pop_front();
            if ({bus.ALU_Out, bus.CarryOut} !== e) begin
               n_err++;
               $display("FAIL reset[%0d]: got out=%h c=%b, want out=%h c=%b",
                        i, bus.ALU_Out, bus.CarryOut, e[W:1], e[0]);
            end
         end
      end
   endtask

   task automatic test_shl();
      vec_t v[$];
      logic [W:0] e;
      v.push_back('{4'd4, 8'h81, 8'h7F, 8'h02});
      v.push_back('{4'd4, 8'h40, 8'h00, 8'h80});
      foreach (v[i]) begin
         drive(v[i].op, v[i].a, v[i].b, 1'b0, {v[i].res, carry_ref(v[i].a, v[i].b)});
         @(posedge clk); #1;
         n_vec++;
         e = exp_q.pop_front();
         if ({bus.ALU_Out, bus.CarryOut} !== e) begin
            n_err++;
            $display("FAIL shl[%0d]: got out=%h c=%b, want out=%h c=%b",
                     i, bus.ALU_Out, bus.CarryOut, e[W:1], e[0]);
         end
      end
   endtask

   task automatic test_arith();
      vec_t v[$];
      logic [W:0] e;
      v.push_back('{4'd1, 8'h00, 8'h01, 8'hFF});
      v.push_back('{4'd2, 8'h10, 8'h10, 8'h00});
      v.push_back('{4'd3, 8'h64, 8'h07, 8'h0E});
      v.push_back('{4'd3, 8'h05, 8'h00, 8'hFF});
      foreach (v[i]) begin
         drive(v[i].op, v[i].a, v[i].b, 1'b0, {v[i].res, carry_ref(v[i].a, v[i].b)});
         @(posedge clk); #1;
         n_vec++;
         e = exp_q.pop_front();
         if ({bus.ALU_Out, bus.CarryOut} !== e) begin
            n_err++;
            $display("FAIL arith[%0d]: got out=%h c=%b, want out=%h c=%b",
                     i, bus.ALU_Out, bus.CarryOut, e[W:1], e[0]);
         end
      end
   endtask

   task automatic test_rotates();
      vec_t v[$];
      logic [W:0] e;
      v.push_back('{4'd6, 8'h81, 8'hA5, 8'h03});
      v.push_back('{4'd7, 8'h81, 8'h5A, 8'hC0});
      v.push_back('{4'd5, 8'h81, 8'hFF, 8'h40});
      foreach (v[i]) begin
         drive(v[i].op, v[i].a, v[i].b, 1'b0, {v[i].res, carry_ref(v[i].a, v[i].b)});
         @(posedge clk); #1;
         n_vec++;
         e = exp_q.pop_front();
         if ({bus.ALU_Out, bus.CarryOut} !== e) begin
            n_err++;
            $display("FAIL rotate[%0d]: got out=%h c=%b, want out=%h c=%b",
                     i, bus.ALU_Out, bus.CarryOut, e[W:1], e[0]);
         end
      end
   endtask

   task automatic test_logic();
      vec_t v[$];
      logic [W:0] e;
      v.push_back('{4'd8,  8'hF0, 8'h3C, 8'h30});
      v.push_back('{4'd9,  8'hF0, 8'h3C, 8'hFC});
      v.push_back('{4'd10, 8'hF0, 8'h3C, 8'hCC});
      v.push_back('{4'd11, 8'hF0, 8'h3C, 8'h03});
      v.push_back('{4'd12, 8'hF0, 8'h3C, 8'hCF});
      v.push_back('{4'd13, 8'hF0, 8'h3C, 8'h33});
      v.push_back('{4'd14, 8'hF0, 8'h3C, 8'h01});
      v.push_back('{4'd15, 8'hF0, 8'h3C, 8'h00});
      v.push_back('{4'd15, 8'h5A, 8'h5A, 8'h01});
      foreach (v[i]) begin
         drive(v[i].op, v[i].a, v[i].b, 1'b0, {v[i].res, carry_ref(v[i].a, v[i].b)});
         @(posedge clk); #1;
         n_vec++;
         e = exp_q.pop_front();
         if ({bus.ALU_Out, bus.CarryOut} !== e) begin
            n_err++;
            $display("FAIL logic[%0d]: got out=%h c=%b, want out=%h c=%b",
                     i, bus.ALU_Out, bus.CarryOut, e[W:1], e[0]);
         end
      end
   endtask

   // Opcode changes every cycle; a single reset cycle lands mid-stream.
   task automatic test_back_to_back();
      logic [W:0]   e;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   op;
      logic         rs;
      for (int i = 0; i < 40; i++) begin
         op = 4'(i);
         a  = 8'($urandom_range(0, 255));
         b  = 8'($urandom_range(0, 255));
         rs = (i == 21);
         drive(op, a, b, rs, rs ? '0 : model(op, a, b));
         @(posedge clk); #1;
         n_vec++;
         e = exp_q.pop_front();
         if ({bus.ALU_Out, bus.CarryOut} !== e) begin
            n_err++;
            $display("FAIL stream[%0d] op=%h a=%h b=%h: got out=%h c=%b, want out=%h c=%b",
                     i, op, a, b, bus.ALU_Out, bus.CarryOut, e[W:1], e[0]);
         end
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.A       = '0;
      bus.B       = '0;
      bus.ALU_Sel = '0;
      @(negedge clk);
      test_reset();
      test_shl();
      test_arith();
      test_rotates();
      test_logic();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d leftover entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at %0t, want completion", $time);
      $fatal(1);
   end

endmodule : tb_alu_unit
